// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the fetch stage.
//   RESET_PC_DEF / EXC_VECTOR_DEF : default boot and exception-entry PCs
//   redir_sel_e                   : which redirect source wins this cycle
//   redir_select()                : fixed-priority encoder over the redirect requests
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'hbfc00000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hbfc00380;

  typedef enum logic [2:0] {
    SelNone,
    SelExc,
    SelEret,
    SelJr,
    SelJ,
    SelBr
  } redir_sel_e;

  // Exception beats ERET beats JR beats J beats a taken conditional branch.
  function automatic redir_sel_e redir_select(input logic exc, input logic eret, input logic jr,
                                              input logic j, input logic br);
    if (exc) begin
      return SelExc;
    end else if (eret) begin
      return SelEret;
    end else if (jr) begin
      return SelJr;
    end else if (j) begin
      return SelJ;
    end else if (br) begin
      return SelBr;
    end
    return SelNone;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Instruction-fetch bus between the PC controller and the instruction memory.
//   inst_req / inst_addr          : request valid and address (master drives)
//   inst_addr_ok                  : request accepted this cycle (slave drives)
//   inst_data_ok / inst_rdata     : in-order response valid and data (slave drives)
interface fetch_pc_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, used for the in-flight PC queue and the result buffer.
//   clk, reset    : clock, asynchronous active-high reset
//   i_flush       : drop every entry (wins over push/pop)
//   i_push/i_data : write when not full
//   i_pop         : discard head when not empty
//   o_data        : head entry (registered storage, no input-to-output path)
//   o_empty       : no entries
//   o_count       : number of entries
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = i_push && (r_count != DEPTH_C);
  assign w_do_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= (r_wptr == LAST_C) ? '0 : r_wptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= (r_rptr == LAST_C) ? '0 : r_rptr + AW'(1);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: owns the PC, issues in-order fetches on the instruction bus,
// tracks in-flight requests, cancels them on redirects and buffers results for decode.
//   clk, reset                 : clock, asynchronous active-high reset
//   fe_allowin                 : decode accepts the fe_* entry this cycle
//   de_br_taken/is_j/is_jr     : branch/jump redirects from decode
//   de_pc, de_br_offset,
//   de_br_index, de_br_target  : operands for the redirect targets
//   de_is_eret, de_eret_target : ERET redirect and its EPC
//   exc_handler                : exception redirect to EXC_VECTOR
//   inst_bus                   : fetch bus (master side)
//   fe_valid/pc/inst/adel      : head of the result buffer (adel = misaligned PC, inst 0)
module fetch_pc_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fe_allowin,
  input  logic                   de_br_taken,
  input  logic                   de_br_is_j,
  input  logic                   de_br_is_jr,
  input  logic [31:0]            de_pc,
  input  logic [15:0]            de_br_offset,
  input  logic [25:0]            de_br_index,
  input  logic [31:0]            de_br_target,
  input  logic                   de_is_eret,
  input  logic [31:0]            de_eret_target,
  input  logic                   exc_handler,
  fetch_pc_ctrl_if.master        inst_bus,
  output logic                   fe_valid,
  output logic [31:0]            fe_pc,
  output logic [31:0]            fe_inst,
  output logic                   fe_adel
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned RBW = 65;  // {pc, inst, adel}
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]    r_pc;
  logic           r_adel_sent;
  // In-flight entries are retired in order and a redirect cancels all of them, so the
  // cancelled ones are always the oldest: a count replaces per-entry flags.
  logic [CW-1:0]  r_cancel_cnt;
  logic [CW-1:0]  w_cancel_d;

  redir_sel_e     w_sel;
  logic           w_redirect;
  logic [31:0]    w_target;
  logic [31:0]    w_br_target;
  logic [31:0]    w_j_target;

  logic [CW-1:0]  w_if_cnt;
  logic [CW-1:0]  w_rb_cnt;
  logic           w_if_empty;
  logic           w_rb_empty;
  logic [31:0]    w_if_head;
  logic [RBW-1:0] w_rb_head;
  logic [RBW-1:0] w_rb_wdata;

  logic           w_space;
  logic           w_aligned;
  logic           w_req;
  logic           w_issue;
  logic           w_resp;
  logic           w_resp_keep;
  logic           w_adel_push;
  logic           w_rb_push;
  logic           w_rb_pop;

  // Redirect target selection
  assign w_sel       = redir_select(exc_handler, de_is_eret, de_br_is_jr, de_br_is_j, de_br_taken);
  assign w_redirect  = (w_sel != SelNone);
  assign w_br_target = de_pc + 32'd4 + {{14{de_br_offset[15]}}, de_br_offset, 2'b00};
  assign w_j_target  = {de_pc[31:28], de_br_index, 2'b00};

  always_comb begin
    w_target = r_pc;
    case (w_sel)
      SelExc:  w_target = EXC_VECTOR;
      SelEret: w_target = de_eret_target;
      SelJr:   w_target = de_br_target;
      SelJ:    w_target = w_j_target;
      SelBr:   w_target = w_br_target;
      default: w_target = r_pc;
    endcase
  end

  // Request issue: cancelled in-flight entries still occupy a slot until they return.
  assign w_space   = ({1'b0, w_if_cnt} + {1'b0, w_rb_cnt}) < DEPTH_C;
  assign w_aligned = (r_pc[1:0] == 2'b00);
  assign w_req     = !reset && !w_redirect && w_aligned && w_space;
  assign w_issue   = w_req && inst_bus.inst_addr_ok;

  assign inst_bus.inst_req  = w_req;
  assign inst_bus.inst_addr = r_pc;

  // Responses: a response in a redirect cycle is dropped along with the flush.
  assign w_resp      = inst_bus.inst_data_ok && !w_if_empty;
  assign w_resp_keep = w_resp && !w_redirect && (r_cancel_cnt == '0);

  // Misaligned PC produces one AdEL entry, then the PC sits frozen until a redirect.
  assign w_adel_push = !reset && !w_redirect && !w_aligned && w_space && !r_adel_sent &&
                       !w_resp_keep;

  assign w_rb_push  = w_resp_keep || w_adel_push;
  assign w_rb_wdata = w_adel_push ? {r_pc, 32'h0, 1'b1} : {w_if_head, inst_bus.inst_rdata, 1'b0};
  assign w_rb_pop   = fe_valid && fe_allowin;

  always_comb begin
    w_cancel_d = r_cancel_cnt;
    if (w_redirect) begin
      w_cancel_d = w_if_cnt - CW'(w_resp) + CW'(w_issue);
    end else if (w_resp && (r_cancel_cnt != '0)) begin
      w_cancel_d = r_cancel_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_adel_sent  <= 1'b0;
      r_cancel_cnt <= '0;
    end else begin
      r_cancel_cnt <= w_cancel_d;
      if (w_redirect) begin
        r_pc        <= w_target;
        r_adel_sent <= 1'b0;
      end else begin
        if (w_issue) begin
          r_pc <= r_pc + 32'd4;
        end
        if (w_adel_push) begin
          r_adel_sent <= 1'b1;
        end
      end
    end
  end

  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_inflight (
    .clk     (clk),
    .reset   (reset),
    .i_flush (1'b0),
    .i_push  (w_issue),
    .i_data  (r_pc),
    .i_pop   (w_resp),
    .o_data  (w_if_head),
    .o_empty (w_if_empty),
    .o_count (w_if_cnt)
  );

  fetch_fifo #(
    .WIDTH (RBW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_result (
    .clk     (clk),
    .reset   (reset),
    .i_flush (w_redirect),
    .i_push  (w_rb_push),
    .i_data  (w_rb_wdata),
    .i_pop   (w_rb_pop),
    .o_data  (w_rb_head),
    .o_empty (w_rb_empty),
    .o_count (w_rb_cnt)
  );

  // Stale storage behind an empty buffer is hidden so idle outputs read as zero.
  assign fe_valid = !w_rb_empty;
  assign fe_pc    = fe_valid ? w_rb_head[64:33] : 32'h0;
  assign fe_inst  = fe_valid ? w_rb_head[32:1]  : 32'h0;
  assign fe_adel  = fe_valid && w_rb_head[0];

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: directed scenarios push expected bus addresses and
// fe_* entries into queues; a monitor compares them as the DUT presents them.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fe_allowin;
  logic        de_br_taken;
  logic        de_br_is_j;
  logic        de_br_is_jr;
  logic [31:0] de_pc;
  logic [15:0] de_br_offset;
  logic [25:0] de_br_index;
  logic [31:0] de_br_target;
  logic        de_is_eret;
  logic [31:0] de_eret_target;
  logic        exc_handler;
  logic        fe_valid;
  logic [31:0] fe_pc;
  logic [31:0] fe_inst;
  logic        fe_adel;

  fetch_pc_ctrl_if bus ();

  fetch_pc_ctrl #(
    .RESET_PC   (32'hbfc00000),
    .EXC_VECTOR (32'hbfc00380),
    .DEPTH      (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fe_allowin     (fe_allowin),
    .de_br_taken    (de_br_taken),
    .de_br_is_j     (de_br_is_j),
    .de_br_is_jr    (de_br_is_jr),
    .de_pc          (de_pc),
    .de_br_offset   (de_br_offset),
    .de_br_index    (de_br_index),
    .de_br_target   (de_br_target),
    .de_is_eret     (de_is_eret),
    .de_eret_target (de_eret_target),
    .exc_handler    (exc_handler),
    .inst_bus       (bus),
    .fe_valid       (fe_valid),
    .fe_pc          (fe_pc),
    .fe_inst        (fe_inst),
    .fe_adel        (fe_adel)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_addr_q[$];
  logic [64:0] exp_fe_q[$];
  logic [31:0] pend_q[$];
  logic        resp_en;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: compares accepted requests and consumed fe_* entries against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b0) begin
        if (bus.inst_req && bus.inst_addr_ok) begin
          if (exp_addr_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL inst_addr_extra: got request %h, required none", bus.inst_addr);
          end else begin
            chk("inst_addr", {33'h0, bus.inst_addr}, {33'h0, exp_addr_q.pop_front()});
          end
        end
        if (fe_valid && fe_allowin) begin
          if (exp_fe_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL fe_extra: got pc=%h inst=%h adel=%b, required none",
                     fe_pc, fe_inst, fe_adel);
          end else begin
            chk("fe_entry", {fe_pc, fe_inst, fe_adel}, exp_fe_q.pop_front());
          end
        end
      end
    end
  end

  // Memory model: in-order responses, one cycle after acceptance when resp_en is set.
  initial begin
    logic        acc_s;
    logic        resp_s;
    logic [31:0] acc_a;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      acc_s  = bus.inst_req && bus.inst_addr_ok;
      acc_a  = bus.inst_addr;
      resp_s = bus.inst_data_ok;
      @(posedge clk);
      #2;
      if (reset) begin
        pend_q.delete();
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
      end else begin
        if (resp_s && pend_q.size() != 0) void'(pend_q.pop_front());
        if (acc_s) pend_q.push_back(acc_a);
        if (resp_en && pend_q.size() != 0) begin
          bus.inst_data_ok = 1'b1;
          bus.inst_rdata   = memf(pend_q[0]);
        end else begin
          bus.inst_data_ok = 1'b0;
          bus.inst_rdata   = 32'h0;
        end
      end
    end
  end

  task automatic clear_de();
    de_br_taken    = 1'b0;
    de_br_is_j     = 1'b0;
    de_br_is_jr    = 1'b0;
    de_pc          = 32'h0;
    de_br_offset   = 16'h0;
    de_br_index    = 26'h0;
    de_br_target   = 32'h0;
    de_is_eret     = 1'b0;
    de_eret_target = 32'h0;
    exc_handler    = 1'b0;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    clear_de();
    bus.inst_addr_ok = 1'b0;
    fe_allowin       = 1'b0;
    resp_en          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Holds addr_ok high until n requests are accepted, then drops it.
  task automatic run_accepts(input int n);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    bus.inst_addr_ok = 1'b1;
    while (k < n && cyc < 40) begin
      @(negedge clk);
      if (bus.inst_req && bus.inst_addr_ok) k++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.inst_addr_ok = 1'b0;
    chk("accept_count", 65'(k), 65'(n));
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((exp_fe_q.size() != 0 || exp_addr_q.size() != 0) && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("drain_left", 65'(exp_fe_q.size() + exp_addr_q.size()), 65'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    int k;
    // Reset values and straight-line fetch
    reset            = 1'b1;
    clear_de();
    bus.inst_addr_ok = 1'b1;
    fe_allowin       = 1'b1;
    resp_en          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_inst_req", {64'h0, bus.inst_req}, 65'h0);
    chk("rst_fe_valid", {64'h0, fe_valid}, 65'h0);
    chk("rst_fe_pc", {33'h0, fe_pc}, 65'h0);
    chk("rst_fe_inst", {33'h0, fe_inst}, 65'h0);
    chk("rst_fe_adel", {64'h0, fe_adel}, 65'h0);
    exp_addr_q = '{32'hbfc00000, 32'hbfc00004, 32'hbfc00008};
    exp_fe_q   = '{{32'hbfc00000, memf(32'hbfc00000), 1'b0},
                   {32'hbfc00004, memf(32'hbfc00004), 1'b0},
                   {32'hbfc00008, memf(32'hbfc00008), 1'b0}};
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_accepts(3);
    drain();

    // Back-pressure: only DEPTH requests outstanding while decode stalls
    do_reset();
    resp_en          = 1'b1;
    bus.inst_addr_ok = 1'b1;
    exp_addr_q = '{32'hbfc00000, 32'hbfc00004, 32'hbfc00008};
    exp_fe_q   = '{{32'hbfc00000, memf(32'hbfc00000), 1'b0},
                   {32'hbfc00004, memf(32'hbfc00004), 1'b0},
                   {32'hbfc00008, memf(32'hbfc00008), 1'b0}};
    k = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.inst_req && bus.inst_addr_ok) k++;
      @(posedge clk);
      #1;
    end
    chk("stall_accepts", 65'(k), 65'(2));
    @(negedge clk);
    chk("stall_inst_req", {64'h0, bus.inst_req}, 65'h0);
    @(posedge clk);
    #1;
    fe_allowin = 1'b1;
    run_accepts(1);
    drain();

    // Taken branch with two in flight; first response coincides with the redirect
    do_reset();
    fe_allowin = 1'b1;
    exp_addr_q = '{32'hbfc00000, 32'hbfc00004, 32'hbfc00024};
    exp_fe_q   = '{{32'hbfc00024, memf(32'hbfc00024), 1'b0}};
    run_accepts(2);
    de_br_taken  = 1'b1;
    de_pc        = 32'hbfc00010;
    de_br_offset = 16'h0004;
    resp_en      = 1'b1;
    @(negedge clk);
    chk("br_cycle_inst_req", {64'h0, bus.inst_req}, 65'h0);
    @(posedge clk);
    #1;
    clear_de();
    run_accepts(1);
    drain();

    // Exception and ERET together: exception wins
    do_reset();
    fe_allowin     = 1'b1;
    resp_en        = 1'b1;
    exc_handler    = 1'b1;
    de_is_eret     = 1'b1;
    de_eret_target = 32'h12345678;
    exp_addr_q = '{32'hbfc00380};
    exp_fe_q   = '{{32'hbfc00380, memf(32'hbfc00380), 1'b0}};
    @(posedge clk);
    #1;
    clear_de();
    run_accepts(1);
    drain();

    // JR to a misaligned target: AdEL entry without a bus request, then a J recovers
    do_reset();
    resp_en      = 1'b1;
    de_br_is_jr  = 1'b1;
    de_br_target = 32'h80000002;
    @(posedge clk);
    #1;
    clear_de();
    bus.inst_addr_ok = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("adel_inst_req", {64'h0, bus.inst_req}, 65'h0);
    chk("adel_fe_valid", {64'h0, fe_valid}, 65'h1);
    chk("adel_fe_pc", {33'h0, fe_pc}, {33'h0, 32'h80000002});
    chk("adel_fe_inst", {33'h0, fe_inst}, 65'h0);
    chk("adel_fe_adel", {64'h0, fe_adel}, 65'h1);
    @(posedge clk);
    #1;
    exp_fe_q   = '{{32'h80000002, 32'h0, 1'b1}};
    fe_allowin = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("adel_once", {64'h0, fe_valid}, 65'h0);
    @(posedge clk);
    #1;
    de_br_is_j  = 1'b1;
    de_pc       = 32'h80000002;
    de_br_index = 26'h0000010;
    exp_addr_q  = '{32'h80000040};
    exp_fe_q    = '{{32'h80000040, memf(32'h80000040), 1'b0}};
    @(negedge clk);
    chk("j_cycle_inst_req", {64'h0, bus.inst_req}, 65'h0);
    @(posedge clk);
    #1;
    clear_de();
    run_accepts(1);
    drain();

    // addr_ok withheld: address held steady, one request on acceptance
    do_reset();
    fe_allowin = 1'b1;
    resp_en    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_inst_req", {64'h0, bus.inst_req}, 65'h1);
      chk("hold_inst_addr", {33'h0, bus.inst_addr}, {33'h0, 32'hbfc00000});
      @(posedge clk);
      #1;
    end
    exp_addr_q = '{32'hbfc00000};
    exp_fe_q   = '{{32'hbfc00000, memf(32'hbfc00000), 1'b0}};
    run_accepts(1);
    @(negedge clk);
    chk("hold_next_addr", {33'h0, bus.inst_addr}, {33'h0, 32'hbfc00004});
    @(posedge clk);
    #1;
    drain();

    // ERET alone, then a taken branch with negative offset
    do_reset();
    fe_allowin     = 1'b1;
    resp_en        = 1'b1;
    de_is_eret     = 1'b1;
    de_eret_target = 32'h00400000;
    exp_addr_q = '{32'h00400000};
    exp_fe_q   = '{{32'h00400000, memf(32'h00400000), 1'b0}};
    @(posedge clk);
    #1;
    clear_de();
    run_accepts(1);
    drain();
    de_br_taken  = 1'b1;
    de_pc        = 32'h00400010;
    de_br_offset = 16'hffff;
    exp_addr_q = '{32'h00400010};
    exp_fe_q   = '{{32'h00400010, memf(32'h00400010), 1'b0}};
    @(posedge clk);
    #1;
    clear_de();
    run_accepts(1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
